completion_buffer_mp: RTL and testbench

Parametrised in-order completion buffer for the out-of-order scalar pipeline. Decode allocates one entry per instruction at the tail. Any of `NUM_WB` functional-unit writeback ports marks entries complete, in any order. Up to `COMMIT_WIDTH` entries retire in order per cycle from the head, with precise exception, branch-mispredict flush and halt handling for the hazard unit.

---
 rtl/completion_buffer_mp_pkg.sv | 20 ++
 rtl/completion_buffer_mp_if.sv | 50 +++++
 rtl/completion_buffer_mp_commit_select.sv | 48 ++++
 rtl/completion_buffer_mp.sv | 158 +++++++++++++++
 tb/tb_completion_buffer_mp.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/completion_buffer_mp_pkg.sv
// Shared types for the in-order completion buffer: word type, entry record
// and the default buffer depth.
package completion_buffer_mp_pkg;

  localparam int NUM_CB_ENTRY = 16;

  typedef logic [31:0] word_t;

  typedef struct packed {
    logic       valid;
    logic       ready;
    logic       wen;
    logic [4:0] vd;
    logic       halt;
    logic       exc;
    logic       mispred;
    word_t      data;
  } cb_entry_t;

endpackage

// File: rtl/completion_buffer_mp_if.sv
// Pipeline-facing bundle of the completion buffer: decode allocation,
// functional-unit writeback and the retire/flush/halt outputs.
interface completion_buffer_mp_if #(
  parameter int NUM_ENTRY    = 16,
  parameter int NUM_WB       = 4,
  parameter int COMMIT_WIDTH = 2
) ();

  localparam int IDX_W = $clog2(NUM_ENTRY);

  logic                      alloc_ena;
  logic [4:0]                alloc_vd;
  logic                      alloc_wen;
  logic                      alloc_halt;
  logic                      full;
  logic                      empty;
  logic [IDX_W-1:0]          cur_tail;

  logic [NUM_WB-1:0]         wb_valid;
  logic [NUM_WB*IDX_W-1:0]   wb_index;
  logic [NUM_WB*32-1:0]      wb_data;
  logic [NUM_WB-1:0]         wb_exception;
  logic [NUM_WB-1:0]         wb_mispredict;

  logic [COMMIT_WIDTH-1:0]   commit_valid;
  logic [COMMIT_WIDTH-1:0]   commit_wen;
  logic [COMMIT_WIDTH*5-1:0] commit_vd;
  logic [COMMIT_WIDTH*32-1:0] commit_wdata;
  logic                      exception;
  logic                      branch_mispredict_ena;
  logic                      flush;
  logic                      halt;

  modport master (
    output alloc_ena, alloc_vd, alloc_wen, alloc_halt,
    output wb_valid, wb_index, wb_data, wb_exception, wb_mispredict,
    input  full, empty, cur_tail,
    input  commit_valid, commit_wen, commit_vd, commit_wdata,
    input  exception, branch_mispredict_ena, flush, halt
  );

  modport slave (
    input  alloc_ena, alloc_vd, alloc_wen, alloc_halt,
    input  wb_valid, wb_index, wb_data, wb_exception, wb_mispredict,
    output full, empty, cur_tail,
    output commit_valid, commit_wen, commit_vd, commit_wdata,
    output exception, branch_mispredict_ena, flush, halt
  );

endinterface

// File: rtl/completion_buffer_mp_commit_select.sv
// Combinational retire decision for the two oldest entries. Slot 1 only
// retires behind a plain slot-0 retirement, so a mispredict or halt always
// ends the retire group.
module completion_buffer_mp_commit_select
  import completion_buffer_mp_pkg::*;
#(
  parameter int COMMIT_WIDTH = 2
) (
  input  cb_entry_t               e0,
  input  cb_entry_t               e1,
  input  logic                    hold,
  output logic [COMMIT_WIDTH-1:0] commit_valid,
  output logic [COMMIT_WIDTH-1:0] commit_wen,
  output logic                    exc_fire,
  output logic                    mispred_fire,
  output logic                    halt_fire,
  output logic [1:0]              head_inc
);

  logic slot0;
  logic slot1;
  logic unused_fields;

  // Head entry decisions: plain retire, fault, mispredict, halt.
  always_comb begin
    slot0        = !hold && e0.valid && e0.ready && !e0.exc;
    exc_fire     = !hold && e0.valid && e0.ready && e0.exc;
    mispred_fire = slot0 && e0.mispred;
    halt_fire    = slot0 && e0.halt;
  end

  if (COMMIT_WIDTH == 2) begin : g_two
    assign slot1 = slot0 && !e0.mispred && !e0.halt &&
                   e1.valid && e1.ready && !e1.exc && !e1.mispred && !e1.halt;
    assign commit_valid = {slot1, slot0};
    assign commit_wen   = {slot1 & e1.wen, slot0 & e0.wen};
  end else begin : g_one
    assign slot1        = 1'b0;
    assign commit_valid = slot0;
    assign commit_wen   = slot0 & e0.wen;
  end

  assign head_inc = {1'b0, slot0} + {1'b0, slot1};

  // Payload fields are consumed by the top level, not by the decision logic.
  assign unused_fields = ^{e0.data, e0.vd, e1.data, e1.vd, e1.wen};

endmodule

// File: rtl/completion_buffer_mp.sv
// In-order completion buffer: tail allocation, any-order writeback marking,
// in-order retirement of up to COMMIT_WIDTH entries with exception, mispredict
// flush and sticky halt.
module completion_buffer_mp
  import completion_buffer_mp_pkg::*;
#(
  parameter int NUM_ENTRY    = NUM_CB_ENTRY,
  parameter int NUM_WB       = 4,
  parameter int COMMIT_WIDTH = 2
) (
  input logic                  CLK,
  input logic                  RST,
  completion_buffer_mp_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_ENTRY);
  localparam logic [IDX_W:0] PTR_ONE = (IDX_W+1)'(1);

  cb_entry_t        entries [NUM_ENTRY];
  logic [IDX_W:0]   head;
  logic [IDX_W:0]   tail;
  logic             halt_q;

  logic [IDX_W-1:0] head_idx;
  logic [IDX_W-1:0] head1_idx;
  logic [IDX_W-1:0] tail_idx;
  cb_entry_t        head_ent [2];

  logic [IDX_W-1:0] wb_idx [NUM_WB];
  logic [NUM_WB-1:0] wb_hit;

  logic [COMMIT_WIDTH-1:0] commit_valid;
  logic [COMMIT_WIDTH-1:0] commit_wen;
  logic             exc_fire;
  logic             mispred_fire;
  logic             halt_fire;
  logic [1:0]       head_inc;
  logic             full;
  logic             empty;
  logic             flush;
  logic             alloc_ok;

  assign head_idx    = head[IDX_W-1:0];
  assign head1_idx   = head_idx + IDX_W'(1);
  assign tail_idx    = tail[IDX_W-1:0];
  assign head_ent[0] = entries[head_idx];
  assign head_ent[1] = entries[head1_idx];

  assign full  = (tail[IDX_W-1:0] == head[IDX_W-1:0]) && (tail[IDX_W] != head[IDX_W]);
  assign empty = (tail == head);
  assign flush = exc_fire | mispred_fire;

  // A full buffer still takes an allocation when the head retires this cycle.
  assign alloc_ok = bus.alloc_ena && !flush && !halt_q && (!full || commit_valid[0]);

  // Reset also suppresses retirement so nothing commits in the reset cycle.
  completion_buffer_mp_commit_select #(
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_commit_select (
    .e0           (head_ent[0]),
    .e1           (head_ent[1]),
    .hold         (RST | halt_q),
    .commit_valid (commit_valid),
    .commit_wen   (commit_wen),
    .exc_fire     (exc_fire),
    .mispred_fire (mispred_fire),
    .halt_fire    (halt_fire),
    .head_inc     (head_inc)
  );

  // Writeback port decode: a port only lands on a live, not-yet-ready entry.
  always_comb begin
    for (int p = 0; p < NUM_WB; p++) begin
      wb_idx[p] = bus.wb_index[p*IDX_W +: IDX_W];
      wb_hit[p] = bus.wb_valid[p] && entries[wb_idx[p]].valid && !entries[wb_idx[p]].ready;
    end
  end

  // Pointer, entry array and halt flag update; later assignments override
  // earlier ones (flush clears writebacks, alloc overwrites a retiring head).
  always_ff @(posedge CLK) begin
    if (RST) begin
      head   <= '0;
      tail   <= '0;
      halt_q <= 1'b0;
      for (int i = 0; i < NUM_ENTRY; i++) begin
        entries[i] <= '0;
      end
    end else begin
      // Highest port first so the lowest-numbered port's write lands last.
      for (int p = NUM_WB - 1; p >= 0; p--) begin
        if (wb_hit[p]) begin
          entries[wb_idx[p]].ready   <= 1'b1;
          entries[wb_idx[p]].data    <= bus.wb_data[p*32 +: 32];
          entries[wb_idx[p]].exc     <= bus.wb_exception[p];
          entries[wb_idx[p]].mispred <= bus.wb_mispredict[p];
        end
      end

      if (commit_valid[0]) begin
        entries[head_idx].valid <= 1'b0;
      end
      if (head_inc == 2'd2) begin
        entries[head1_idx].valid <= 1'b0;
      end
      head <= head + (IDX_W+1)'(head_inc);

      if (mispred_fire) begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
          entries[i].valid <= 1'b0;
        end
        tail <= head + PTR_ONE;
      end else if (exc_fire) begin
        for (int i = 0; i < NUM_ENTRY; i++) begin
          entries[i].valid <= 1'b0;
        end
        tail <= head;
      end else if (alloc_ok) begin
        entries[tail_idx] <= '{valid:   1'b1,
                               ready:   1'b0,
                               wen:     bus.alloc_wen,
                               vd:      bus.alloc_vd,
                               halt:    bus.alloc_halt,
                               exc:     1'b0,
                               mispred: 1'b0,
                               data:    '0};
        tail <= tail + PTR_ONE;
      end

      if (halt_fire) begin
        halt_q <= 1'b1;
      end
    end
  end

  // Retire payload per slot, zeroed when the slot does not fire.
  always_comb begin
    bus.commit_vd    = '0;
    bus.commit_wdata = '0;
    for (int s = 0; s < COMMIT_WIDTH; s++) begin
      if (commit_valid[s]) begin
        bus.commit_vd[s*5 +: 5]     = head_ent[s].vd;
        bus.commit_wdata[s*32 +: 32] = head_ent[s].data;
      end
    end
  end

  assign bus.commit_valid          = commit_valid;
  assign bus.commit_wen            = commit_wen;
  assign bus.exception             = exc_fire;
  assign bus.branch_mispredict_ena = mispred_fire;
  assign bus.flush                 = flush;
  assign bus.halt                  = halt_q;
  assign bus.full                  = full;
  assign bus.empty                 = empty;
  assign bus.cur_tail              = tail_idx;

endmodule

// File: tb/tb_completion_buffer_mp.sv
// Directed bench for completion_buffer_mp: inputs change and outputs are
// sampled on the falling edge, state moves on the rising edge.
module tb_completion_buffer_mp;

  logic CLK;
  logic RST;
  int   n_checks;
  int   n_fail;

  completion_buffer_mp_if #(.NUM_ENTRY(16), .NUM_WB(4), .COMMIT_WIDTH(2)) bus ();

  completion_buffer_mp #(.NUM_ENTRY(16), .NUM_WB(4), .COMMIT_WIDTH(2)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic idle();
    bus.alloc_ena     = 1'b0;
    bus.alloc_vd      = '0;
    bus.alloc_wen     = 1'b0;
    bus.alloc_halt    = 1'b0;
    bus.wb_valid      = '0;
    bus.wb_index      = '0;
    bus.wb_data       = '0;
    bus.wb_exception  = '0;
    bus.wb_mispredict = '0;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    idle();
    repeat (2) @(negedge CLK);
    RST = 1'b0;
  endtask

  task automatic alloc(input logic [4:0] vd, input logic wen, input logic hlt);
    bus.alloc_ena  = 1'b1;
    bus.alloc_vd   = vd;
    bus.alloc_wen  = wen;
    bus.alloc_halt = hlt;
    @(negedge CLK);
    bus.alloc_ena  = 1'b0;
    bus.alloc_halt = 1'b0;
  endtask

  task automatic wb_set(input int p, input logic [3:0] idx, input logic [31:0] d,
                        input logic exc, input logic mis);
    bus.wb_valid[p]          = 1'b1;
    bus.wb_index[p*4 +: 4]   = idx;
    bus.wb_data[p*32 +: 32]  = d;
    bus.wb_exception[p]      = exc;
    bus.wb_mispredict[p]     = mis;
  endtask

  task automatic wb_step();
    @(negedge CLK);
    bus.wb_valid      = '0;
    bus.wb_exception  = '0;
    bus.wb_mispredict = '0;
  endtask

  task automatic wb1(input int p, input logic [3:0] idx, input logic [31:0] d,
                     input logic exc, input logic mis);
    wb_set(p, idx, d, exc, mis);
    wb_step();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++;
    if (bus.empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty: got %b want 1", bus.empty); end
    n_checks++;
    if (bus.full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", bus.full); end
    n_checks++;
    if (bus.cur_tail !== 4'd0) begin n_fail++; $display("FAIL reset_tail: got %0d want 0", bus.cur_tail); end
    n_checks++;
    if (bus.commit_valid !== 2'b00) begin n_fail++; $display("FAIL reset_commit: got %b want 00", bus.commit_valid); end
    n_checks++;
    if (bus.flush !== 1'b0 || bus.exception !== 1'b0 || bus.halt !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: flush %b exc %b halt %b want 0 0 0", bus.flush, bus.exception, bus.halt);
    end
  endtask

  task automatic test_full();
    do_reset();
    bus.alloc_ena = 1'b1;
    bus.alloc_vd  = 5'd9;
    bus.alloc_wen = 1'b1;
    repeat (15) @(negedge CLK);
    n_checks++;
    if (bus.full !== 1'b0 || bus.cur_tail !== 4'd15) begin
      n_fail++; $display("FAIL full_at15: full %b tail %0d want 0 15", bus.full, bus.cur_tail);
    end
    @(negedge CLK);
    n_checks++;
    if (bus.full !== 1'b1 || bus.cur_tail !== 4'd0 || bus.empty !== 1'b0) begin
      n_fail++; $display("FAIL full_at16: full %b tail %0d empty %b want 1 0 0", bus.full, bus.cur_tail, bus.empty);
    end
    @(negedge CLK);
    bus.alloc_ena = 1'b0;
    n_checks++;
    if (bus.full !== 1'b1 || bus.cur_tail !== 4'd0) begin
      n_fail++; $display("FAIL full_drop17: full %b tail %0d want 1 0", bus.full, bus.cur_tail);
    end
    wb1(0, 4'd0, 32'h99, 1'b0, 1'b0);
    n_checks++;
    if (bus.commit_valid !== 2'b01 || bus.commit_wdata[31:0] !== 32'h99) begin
      n_fail++; $display("FAIL full_commit: valid %b data %h want 01 99", bus.commit_valid, bus.commit_wdata[31:0]);
    end
    alloc(5'd11, 1'b1, 1'b0);
    n_checks++;
    if (bus.cur_tail !== 4'd1 || bus.full !== 1'b1) begin
      n_fail++; $display("FAIL full_alloc_commit: tail %0d full %b want 1 1", bus.cur_tail, bus.full);
    end
  endtask

  task automatic test_commit_two();
    do_reset();
    for (int i = 1; i <= 4; i++) alloc(5'(i), 1'b1, 1'b0);
    wb1(3, 4'd1, 32'hB, 1'b0, 1'b0);
    n_checks++;
    if (bus.commit_valid !== 2'b00) begin n_fail++; $display("FAIL two_wait: got %b want 00", bus.commit_valid); end
    wb1(0, 4'd0, 32'hA, 1'b0, 1'b0);
    n_checks++;
    if (bus.commit_valid !== 2'b11 || bus.commit_wen !== 2'b11) begin
      n_fail++; $display("FAIL two_valid: valid %b wen %b want 11 11", bus.commit_valid, bus.commit_wen);
    end
    n_checks++;
    if (bus.commit_vd !== {5'd2, 5'd1} || bus.commit_wdata !== {32'hB, 32'hA}) begin
      n_fail++; $display("FAIL two_payload: vd %h data %h want 041 0000000b0000000a", bus.commit_vd, bus.commit_wdata);
    end
    @(negedge CLK);
    n_checks++;
    if (bus.commit_valid !== 2'b00 || bus.cur_tail !== 4'd4 || bus.empty !== 1'b0) begin
      n_fail++; $display("FAIL two_after: valid %b tail %0d empty %b want 00 4 0", bus.commit_valid, bus.cur_tail, bus.empty);
    end
    wb1(0, 4'd2, 32'hC, 1'b0, 1'b0);
    n_checks++;
    if (bus.commit_valid !== 2'b01 || bus.commit_vd !== {5'd0, 5'd3} || bus.commit_wdata !== {32'h0, 32'hC}) begin
      n_fail++; $display("FAIL two_head2: valid %b vd %h data %h want 01 003 c", bus.commit_valid, bus.commit_vd, bus.commit_wdata);
    end
  endtask

  task automatic test_exception();
    do_reset();
    alloc(5'd1, 1'b1, 1'b0);
    alloc(5'd2, 1'b1, 1'b0);
    wb1(2, 4'd0, 32'h5, 1'b1, 1'b0);
    n_checks++;
    if (bus.exception !== 1'b1 || bus.flush !== 1'b1 || bus.branch_mispredict_ena !== 1'b0) begin
      n_fail++; $display("FAIL exc_pulse: exc %b flush %b misp %b want 1 1 0", bus.exception, bus.flush, bus.branch_mispredict_ena);
    end
    n_checks++;
    if (bus.commit_valid !== 2'b00) begin n_fail++; $display("FAIL exc_nocommit: got %b want 00", bus.commit_valid); end
    wb1(1, 4'd1, 32'h33, 1'b0, 1'b0);
    n_checks++;
    if (bus.exception !== 1'b0 || bus.empty !== 1'b1 || bus.cur_tail !== 4'd0) begin
      n_fail++; $display("FAIL exc_after: exc %b empty %b tail %0d want 0 1 0", bus.exception, bus.empty, bus.cur_tail);
    end
    alloc(5'd7, 1'b1, 1'b0);
    alloc(5'd8, 1'b1, 1'b0);
    wb1(0, 4'd0, 32'h44, 1'b0, 1'b0);
    n_checks++;
    if (bus.commit_valid !== 2'b01 || bus.commit_vd[4:0] !== 5'd7) begin
      n_fail++; $display("FAIL exc_realloc: valid %b vd %0d want 01 7", bus.commit_valid, bus.commit_vd[4:0]);
    end
  endtask

  task automatic test_mispredict();
    do_reset();
    alloc(5'd1, 1'b1, 1'b0);
    alloc(5'd2, 1'b1, 1'b0);
    wb1(1, 4'd1, 32'h77, 1'b0, 1'b0);
    wb1(0, 4'd0, 32'h40, 1'b0, 1'b1);
    n_checks++;
    if (bus.commit_valid !== 2'b01 || bus.commit_wen !== 2'b01) begin
      n_fail++; $display("FAIL misp_valid: valid %b wen %b want 01 01", bus.commit_valid, bus.commit_wen);
    end
    n_checks++;
    if (bus.commit_vd[4:0] !== 5'd1 || bus.commit_wdata[31:0] !== 32'h40) begin
      n_fail++; $display("FAIL misp_payload: vd %0d data %h want 1 40", bus.commit_vd[4:0], bus.commit_wdata[31:0]);
    end
    n_checks++;
    if (bus.branch_mispredict_ena !== 1'b1 || bus.flush !== 1'b1 || bus.exception !== 1'b0) begin
      n_fail++; $display("FAIL misp_flags: misp %b flush %b exc %b want 1 1 0", bus.branch_mispredict_ena, bus.flush, bus.exception);
    end
    @(negedge CLK);
    n_checks++;
    if (bus.empty !== 1'b1 || bus.cur_tail !== 4'd1 || bus.flush !== 1'b0) begin
      n_fail++; $display("FAIL misp_after: empty %b tail %0d flush %b want 1 1 0", bus.empty, bus.cur_tail, bus.flush);
    end
  endtask

  task automatic test_wb_priority();
    do_reset();
    alloc(5'd5, 1'b1, 1'b0);
    wb_set(0, 4'd0, 32'h1, 1'b0, 1'b0);
    wb_set(1, 4'd0, 32'h2, 1'b0, 1'b0);
    wb_step();
    n_checks++;
    if (bus.commit_valid !== 2'b01 || bus.commit_wdata[31:0] !== 32'h1) begin
      n_fail++; $display("FAIL wb_priority: valid %b data %h want 01 1", bus.commit_valid, bus.commit_wdata[31:0]);
    end
  endtask

  task automatic test_halt();
    do_reset();
    alloc(5'd3, 1'b1, 1'b0);
    alloc(5'd0, 1'b0, 1'b1);
    alloc(5'd7, 1'b1, 1'b0);
    wb_set(0, 4'd0, 32'h10, 1'b0, 1'b0);
    wb_set(1, 4'd1, 32'h0, 1'b0, 1'b0);
    wb_set(2, 4'd2, 32'h70, 1'b0, 1'b0);
    wb_step();
    n_checks++;
    if (bus.commit_valid !== 2'b01 || bus.commit_vd[4:0] !== 5'd3 || bus.halt !== 1'b0) begin
      n_fail++; $display("FAIL halt_first: valid %b vd %0d halt %b want 01 3 0", bus.commit_valid, bus.commit_vd[4:0], bus.halt);
    end
    @(negedge CLK);
    n_checks++;
    if (bus.commit_valid !== 2'b01 || bus.commit_wen !== 2'b00 || bus.halt !== 1'b0) begin
      n_fail++; $display("FAIL halt_retire: valid %b wen %b halt %b want 01 00 0", bus.commit_valid, bus.commit_wen, bus.halt);
    end
    @(negedge CLK);
    n_checks++;
    if (bus.halt !== 1'b1 || bus.commit_valid !== 2'b00 || bus.cur_tail !== 4'd3) begin
      n_fail++; $display("FAIL halt_set: halt %b valid %b tail %0d want 1 00 3", bus.halt, bus.commit_valid, bus.cur_tail);
    end
    alloc(5'd9, 1'b1, 1'b0);
    n_checks++;
    if (bus.cur_tail !== 4'd3) begin n_fail++; $display("FAIL halt_alloc_block: tail %0d want 3", bus.cur_tail); end
    repeat (3) @(negedge CLK);
    n_checks++;
    if (bus.halt !== 1'b1 || bus.commit_valid !== 2'b00) begin
      n_fail++; $display("FAIL halt_sticky: halt %b valid %b want 1 00", bus.halt, bus.commit_valid);
    end
    do_reset();
    n_checks++;
    if (bus.halt !== 1'b0 || bus.empty !== 1'b1) begin
      n_fail++; $display("FAIL halt_reset: halt %b empty %b want 0 1", bus.halt, bus.empty);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    RST      = 1'b1;
    idle();
    @(negedge CLK);
    test_reset();
    test_full();
    test_commit_two();
    test_exception();
    test_mispredict();
    test_wb_priority();
    test_halt();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
